// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU sequencer:
// state codes, opcodes and ALU operation selects.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR    = 4'd1,
    S_FETCH   = 4'd2,
    S_INC     = 4'd3,
    S_DEC     = 4'd4,
    S_OPADDR  = 4'd5,
    S_OPREAD  = 4'd6,
    S_EXEC    = 4'd7,
    S_HALT    = 4'd8,
    S_ERR     = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_OUT = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired flags the last
// cycle in which an acknowledge is still accepted.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (reset_p || clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 4'd1;
    end
  end

  assign expired = (count == 4'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Control sequencer for a small accumulator CPU:
// fetch / decode / execute FSM with memory timeout.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       run,
  input  logic [3:0] ir_opcode,
  input  logic       zero_flag,
  input  logic       mem_ack,
  output logic       pc_inc,
  output logic       load_pc,
  output logic       pc_rd_en,
  output logic       mar_load,
  output logic       mem_rd,
  output logic       ir_load,
  output logic       ir_rd_en,
  output logic       acc_load,
  output logic [1:0] alu_op,
  output logic       out_load,
  output logic       halted,
  output logic       err,
  output logic [3:0] state_out
);

  state_t state, state_nx;
  logic   in_wait;
  logic   expired;
  logic   is_jump;

  assign in_wait = (state == S_FETCH) ||
                   (state == S_OPREAD);
  assign is_jump = (ir_opcode == OP_JMP) ||
                   (ir_opcode == OP_JZ);

  // Counter rests at zero outside the two read
  // states, so entering either starts a fresh count.
  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset_p  (reset_p),
    .clear    (!in_wait),
    .count_en (in_wait && !mem_ack),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (run) state_nx = S_ADDR;
      S_ADDR:   state_nx = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (mem_ack)      state_nx = S_INC;
        else if (expired) state_nx = S_ERR;
      end
      S_INC:    state_nx = S_DEC;
      S_DEC: begin
        unique case (ir_opcode)
          OP_LDA, OP_ADD, OP_SUB:
            state_nx = S_OPADDR;
          OP_OUT, OP_JMP:
            state_nx = S_EXEC;
          OP_JZ:
            state_nx = zero_flag ? S_EXEC : S_ADDR;
          OP_HLT:
            state_nx = S_HALT;
          default:
            state_nx = S_ADDR;
        endcase
      end
      S_OPADDR: state_nx = S_OPREAD;
      S_OPREAD: begin
        if (mem_ack)      state_nx = S_ADDR;
        else if (expired) state_nx = S_ERR;
      end
      S_EXEC:   state_nx = S_ADDR;
      S_HALT:   state_nx = S_HALT;
      S_ERR:    state_nx = S_ERR;
      default:  state_nx = S_ERR;
    endcase
  end

  always_comb begin
    pc_inc   = 1'b0;
    load_pc  = 1'b0;
    pc_rd_en = 1'b0;
    mar_load = 1'b0;
    mem_rd   = 1'b0;
    ir_rd_en = 1'b0;
    out_load = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;
    unique case (1'b1)
      (state == S_ADDR): begin
        pc_rd_en = 1'b1;
        mar_load = 1'b1;
      end
      (state == S_FETCH):  mem_rd = 1'b1;
      (state == S_INC):    pc_inc = 1'b1;
      (state == S_OPADDR): begin
        ir_rd_en = 1'b1;
        mar_load = 1'b1;
      end
      (state == S_OPREAD): mem_rd = 1'b1;
      (state == S_EXEC): begin
        ir_rd_en = is_jump;
        load_pc  = is_jump;
        out_load = (ir_opcode == OP_OUT);
      end
      (state == S_HALT):   halted = 1'b1;
      (state == S_ERR):    err = 1'b1;
      default: ;
    endcase
  end

  assign ir_load  = (state == S_FETCH) && mem_ack;
  assign acc_load = (state == S_OPREAD) && mem_ack;

  always_comb begin
    alu_op = ALU_PASS;
    if (acc_load) begin
      unique case (ir_opcode)
        OP_ADD:  alu_op = ALU_ADD;
        OP_SUB:  alu_op = ALU_SUB;
        default: alu_op = ALU_PASS;
      endcase
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; expected state and
// control vectors are queued per cycle and checked.
module tb_cpu_sequencer;

  localparam logic [3:0] I_IDLE = 4'd0;
  localparam logic [3:0] I_ADDR = 4'd1;
  localparam logic [3:0] I_FTCH = 4'd2;
  localparam logic [3:0] I_INC  = 4'd3;
  localparam logic [3:0] I_DEC  = 4'd4;
  localparam logic [3:0] I_OPA  = 4'd5;
  localparam logic [3:0] I_OPR  = 4'd6;
  localparam logic [3:0] I_EXEC = 4'd7;
  localparam logic [3:0] I_HALT = 4'd8;
  localparam logic [3:0] I_ERR  = 4'd9;

  // {pc_inc,load_pc,pc_rd_en,mar_load,mem_rd,ir_load,
  //  ir_rd_en,acc_load,alu_op[1:0],out_load,halted,err}
  localparam logic [12:0] K_NONE = 13'b0_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] K_ADDR = 13'b0_0_1_1_0_0_0_0_00_0_0_0;
  localparam logic [12:0] K_FTCH = 13'b0_0_0_0_1_0_0_0_00_0_0_0;
  localparam logic [12:0] K_FACK = 13'b0_0_0_0_1_1_0_0_00_0_0_0;
  localparam logic [12:0] K_INC  = 13'b1_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] K_OPA  = 13'b0_0_0_1_0_0_1_0_00_0_0_0;
  localparam logic [12:0] K_OPR  = 13'b0_0_0_0_1_0_0_0_00_0_0_0;
  localparam logic [12:0] K_LDA  = 13'b0_0_0_0_1_0_0_1_00_0_0_0;
  localparam logic [12:0] K_ADD  = 13'b0_0_0_0_1_0_0_1_01_0_0_0;
  localparam logic [12:0] K_SUB  = 13'b0_0_0_0_1_0_0_1_10_0_0_0;
  localparam logic [12:0] K_JMP  = 13'b0_1_0_0_0_0_1_0_00_0_0_0;
  localparam logic [12:0] K_OUT  = 13'b0_0_0_0_0_0_0_0_00_1_0_0;
  localparam logic [12:0] K_HALT = 13'b0_0_0_0_0_0_0_0_00_0_1_0;
  localparam logic [12:0] K_ERR  = 13'b0_0_0_0_0_0_0_0_00_0_0_1;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [12:0] ctl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_p;
  logic       run;
  logic [3:0] ir_opcode;
  logic       zero_flag;
  logic       mem_ack;
  logic       pc_inc, load_pc, pc_rd_en, mar_load;
  logic       mem_rd, ir_load, ir_rd_en, acc_load;
  logic [1:0] alu_op;
  logic       out_load, halted, err;
  logic [3:0] state_out;
  logic [12:0] ctl_vec;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .MEM_TIMEOUT (3)
  ) dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .run       (run),
    .ir_opcode (ir_opcode),
    .zero_flag (zero_flag),
    .mem_ack   (mem_ack),
    .pc_inc    (pc_inc),
    .load_pc   (load_pc),
    .pc_rd_en  (pc_rd_en),
    .mar_load  (mar_load),
    .mem_rd    (mem_rd),
    .ir_load   (ir_load),
    .ir_rd_en  (ir_rd_en),
    .acc_load  (acc_load),
    .alu_op    (alu_op),
    .out_load  (out_load),
    .halted    (halted),
    .err       (err),
    .state_out (state_out)
  );

  assign ctl_vec = {pc_inc, load_pc, pc_rd_en, mar_load,
                    mem_rd, ir_load, ir_rd_en, acc_load,
                    alu_op, out_load, halted, err};

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    checks++;
    assert (state_out === e.st) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d",
             e.tag, state_out, e.st);
    end
    checks++;
    assert (ctl_vec === e.ctl) else begin
      errors++;
      $error("FAIL %s ctl observed=%b expected=%b",
             e.tag, ctl_vec, e.ctl);
    end
    checks++;
    assert (!(pc_inc && load_pc) &&
            !(pc_rd_en && ir_rd_en)) else begin
      errors++;
      $error("FAIL %s exclusive observed=%b expected=no_overlap",
             e.tag, ctl_vec);
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] op,
                     input logic zf, input logic ack,
                     input logic [3:0] es,
                     input logic [12:0] ek,
                     input string tag);
    exp_t e;
    run       = r;
    ir_opcode = op;
    zero_flag = zf;
    mem_ack   = ack;
    e.tag = tag;
    e.st  = es;
    e.ctl = ek;
    exp_q.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] op, input logic zf);
    cyc(1, op, zf, 0, I_ADDR, K_ADDR, "addr");
    cyc(1, op, zf, 1, I_FTCH, K_FACK, "fetch");
    cyc(1, op, zf, 0, I_INC,  K_INC,  "inc");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_p = 1'b1; run = 1'b0; ir_opcode = 4'h0;
    zero_flag = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    reset_p = 1'b0;

    cyc(0, 4'h0, 0, 1, I_IDLE, K_NONE, "reset_idle");
    cyc(1, 4'h1, 0, 0, I_IDLE, K_NONE, "idle_run");

    fetch(4'h1, 0);
    cyc(1, 4'h1, 0, 0, I_DEC,  K_NONE, "lda_dec");
    cyc(1, 4'h1, 0, 0, I_OPA,  K_OPA,  "lda_opaddr");
    cyc(1, 4'h1, 0, 1, I_OPR,  K_LDA,  "lda_read");

    fetch(4'h2, 0);
    cyc(1, 4'h2, 0, 0, I_DEC,  K_NONE, "add_dec");
    cyc(1, 4'h2, 0, 0, I_OPA,  K_OPA,  "add_opaddr");
    cyc(1, 4'h2, 0, 1, I_OPR,  K_ADD,  "add_read");

    fetch(4'h3, 1);
    cyc(1, 4'h3, 1, 0, I_DEC,  K_NONE, "sub_dec");
    cyc(1, 4'h3, 1, 0, I_OPA,  K_OPA,  "sub_opaddr");
    cyc(1, 4'h3, 1, 0, I_OPR,  K_OPR,  "sub_wait");
    cyc(1, 4'h3, 1, 1, I_OPR,  K_SUB,  "sub_read");

    fetch(4'h6, 0);
    cyc(1, 4'h6, 0, 0, I_DEC,  K_NONE, "jz_nt_dec");

    fetch(4'h6, 1);
    cyc(1, 4'h6, 1, 0, I_DEC,  K_NONE, "jz_t_dec");
    cyc(1, 4'h6, 1, 0, I_EXEC, K_JMP,  "jz_t_exec");

    fetch(4'h5, 0);
    cyc(1, 4'h5, 0, 0, I_DEC,  K_NONE, "jmp_dec");
    cyc(1, 4'h5, 0, 0, I_EXEC, K_JMP,  "jmp_exec");

    fetch(4'h9, 0);
    cyc(1, 4'h9, 0, 0, I_DEC,  K_NONE, "nop9_dec");

    fetch(4'h4, 0);
    cyc(1, 4'h4, 0, 0, I_DEC,  K_NONE, "out_dec");
    cyc(0, 4'h4, 0, 0, I_EXEC, K_OUT,  "out_exec_norun");
    cyc(0, 4'h4, 0, 0, I_ADDR, K_ADDR, "pause_addr");
    cyc(0, 4'h4, 0, 1, I_IDLE, K_NONE, "pause_idle");
    cyc(1, 4'h0, 0, 0, I_IDLE, K_NONE, "resume_idle");

    cyc(1, 4'h0, 0, 0, I_ADDR, K_ADDR, "slow_addr");
    cyc(1, 4'h0, 0, 0, I_FTCH, K_FTCH, "slow_w0");
    cyc(1, 4'h0, 0, 0, I_FTCH, K_FTCH, "slow_w1");
    cyc(1, 4'h0, 0, 1, I_FTCH, K_FACK, "slow_last_ack");
    cyc(1, 4'h0, 0, 0, I_INC,  K_INC,  "slow_inc");
    cyc(1, 4'h0, 0, 0, I_DEC,  K_NONE, "slow_dec");

    fetch(4'h2, 0);
    cyc(1, 4'h2, 0, 0, I_DEC,  K_NONE, "rst_dec");
    cyc(1, 4'h2, 0, 0, I_OPA,  K_OPA,  "rst_opaddr");
    cyc(1, 4'h2, 0, 0, I_OPR,  K_OPR,  "rst_wait");
    reset_p = 1'b1;
    cyc(1, 4'h2, 0, 0, I_OPR,  K_OPR,  "rst_edge");
    reset_p = 1'b0;
    cyc(1, 4'h2, 0, 1, I_IDLE, K_NONE, "rst_after");

    cyc(1, 4'h0, 0, 0, I_ADDR, K_ADDR, "to_addr");
    cyc(1, 4'h0, 0, 0, I_FTCH, K_FTCH, "to_w0");
    cyc(1, 4'h0, 0, 0, I_FTCH, K_FTCH, "to_w1");
    cyc(1, 4'h0, 0, 0, I_FTCH, K_FTCH, "to_w2");
    for (int i = 0; i < 4; i++) begin
      cyc(1, 4'h0, 0, i[0], I_ERR, K_ERR, "err_hold");
    end
    reset_p = 1'b1;
    cyc(1, 4'h0, 0, 0, I_ERR,  K_ERR,  "err_rst");
    reset_p = 1'b0;
    cyc(0, 4'h0, 0, 0, I_IDLE, K_NONE, "err_clear");
    cyc(1, 4'hF, 0, 0, I_IDLE, K_NONE, "hlt_start");

    fetch(4'hF, 0);
    cyc(1, 4'hF, 0, 0, I_DEC,  K_NONE, "hlt_dec");
    for (int i = 0; i < 20; i++) begin
      cyc(i[0], 4'hF, 0, i[1], I_HALT, K_HALT, "halt_hold");
    end
    reset_p = 1'b1;
    cyc(1, 4'hF, 0, 0, I_HALT, K_HALT, "halt_rst");
    reset_p = 1'b0;
    cyc(0, 4'h0, 0, 0, I_IDLE, K_NONE, "halt_clear");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_left observed=%0d expected=0",
             exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
